branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences branch prediction against branch resolution in the 5-stage pipeline.
- ID pushes each conditional branch, with its predicted direction and addresses, into an in-order in-flight queue.
- EX resolves the oldest entry. On a mispredict the block issues redirect and flush, and it strobes the 2-bit PHT/BHR predictor update in every resolution case.
- Sits between the ID-stage target adder/predictor, the EX comparator and the PC/pipeline-register control.

Parameters:
DEPTH, 4, in-flight branch queue entries; power of 2, minimum 2
FLUSH_CYCLES, 2, cycles flush is held after a mispredict; minimum 1
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
id_push  input  1  ID issues a conditional branch (BEQ/BLT/BGE) this cycle
id_pred_taken  input  1  predictor direction for pushed branch
id_pc  input  32  instruction address of pushed branch
id_imm  input  32  sign-extended branch offset
id_ready  output  1  push accepted this cycle (combinational)
ex_valid  input  1  EX resolved the oldest in-flight branch
ex_taken  input  1  actual outcome from EX comparator
redirect  output  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  output  32  corrected fetch address
flush  output  1  kill IF/ID contents
upd_we  output  1  predictor update strobe
upd_taken  output  1  outcome for predictor update
upd_pc  output  32  address of resolved branch
branch_cnt  output  CNT_W  resolved branches
mispred_cnt  output  CNT_W  mispredicted branches

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous, active-low. All state clears on rst_n low.
- Reset values:
  - queue empty, state IDLE
  - redirect, flush, upd_we, upd_taken = 0
  - redirect_pc, upd_pc = 0
  - counters = 0
- Reset mid-flush aborts the flush immediately.
- Queue entry contents: {pred, pc, target = pc + imm, fall = pc + 4}. Both sums are 32-bit, modulo 2^32 (wrap silently).
- FIFO order: push at tail, pop at head. Count is tracked as 0..DEPTH.
- id_ready = (state == IDLE) && (count < DEPTH).
  - id_push with id_ready low is dropped; the upstream must stall.
- States: IDLE and FLUSH.
- IDLE, ex_valid with count > 0: pop the head. On the next edge (registered, 1-cycle latency):
  - upd_we = 1 for one cycle; upd_taken = ex_taken; upd_pc = head.pc.
  - If ex_taken == head.pred: no redirect; state stays IDLE.
  - If ex_taken != head.pred:
    - redirect = 1 for one cycle; redirect_pc = ex_taken ? head.target : head.fall.
    - flush = 1.
    - Entire queue cleared: all younger entries are wrong-path.
    - Go to FLUSH with the flush counter loaded to FLUSH_CYCLES-1.
- IDLE, ex_valid with count == 0: ignored. No pop, no upd_we, no counter change.
- Simultaneous push and pop in IDLE:
  - Correct prediction: both occur; count unchanged.
  - Mispredict: the push is discarded; the queue ends empty.
- Push with count == DEPTH and a simultaneous pop: rejected, because id_ready is computed from the current count.
- FLUSH:
  - flush held high; id_push and ex_valid ignored.
  - Counter decrements each cycle; return to IDLE on the cycle after it reaches 0.
  - flush is high for exactly FLUSH_CYCLES consecutive cycles, counting from the cycle redirect pulses.
- Counters (per Optional Feature):
  - branch_cnt increments on each upd_we.
  - mispred_cnt increments on each redirect.
  - Both saturate at all-ones; no wrap.

Optional Feature:
- Macro BRC_PERF_CNT_EN.
- Defined: branch_cnt and mispred_cnt are implemented as described.
- Undefined: no counter registers; both outputs are tied to 0; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-FLUSH -> flush, redirect, upd_we = 0 immediately; id_ready=1 after release; counters 0.
- Correct taken prediction: push pc=0x100, imm=0x20, pred=1; then ex_valid=1, ex_taken=1 -> next cycle upd_we=1, upd_pc=0x100, upd_taken=1, redirect=0, flush=0, branch_cnt=1.
- Mispredict not-taken-as-taken: push pc=0x200, imm=0x40, pred=1, plus 2 younger pushes; ex_taken=0 ->
  - redirect=1 for 1 cycle, redirect_pc=0x204;
  - flush high for exactly 2 cycles; id_ready=0 during flush;
  - queue empty afterwards (later ex_valid is ignored);
  - mispred_cnt=1.
- Mispredict taken with wrap: push pc=0xFFFFFFF0, imm=0x20, pred=0; ex_taken=1 -> redirect_pc=0x00000010.
- Full/simultaneous:
  - Push DEPTH=4 entries -> id_ready=0; a 5th push is dropped.
  - Pop with correct prediction while pushing -> count stays 4.
  - Mispredict pop with a concurrent push -> queue empty.
- ex_valid on empty queue -> no upd_we, no redirect, counters unchanged. With BRC_PERF_CNT_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Purpose : tracks in-flight conditional branches from ID and resolves the oldest one against the
//           EX outcome, driving the predictor update, the redirect and the flush.
// Latency : one cycle from ex_valid to upd_we/redirect, and flush follows redirect in the same cycle.
//           Backpressure: id_ready drops when the queue is full or a flush is in progress.
// Ports   : clk/rst_n; ID push (id_push, id_pred_taken, id_pc, id_imm, id_ready); EX resolve
//           (ex_valid, ex_taken); redirect/redirect_pc/flush to PC control; upd_* to the predictor;
//           branch_cnt/mispred_cnt perf counters, which exist only when BRC_PERF_CNT_EN is defined.
module branch_resolve_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_push,
    input  logic             id_pred_taken,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    output logic             id_ready,
    input  logic             ex_valid,
    input  logic             ex_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             upd_we,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;

    logic [DEPTH-1:0]  q_pred;
    logic [31:0]       q_pc   [DEPTH];
    logic [31:0]       q_tgt  [DEPTH];
    logic [31:0]       q_fall [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [QC_W-1:0]   count;

    logic pop, mispred, push_ok;

    assign id_ready = (state_q == IDLE) && (count < QC_W'(DEPTH));
    assign pop      = (state_q == IDLE) && ex_valid && (count != '0);
    assign mispred  = pop && (ex_taken != q_pred[head]);
    // A push in the same cycle as a mispredict is wrong-path and is discarded.
    assign push_ok  = id_push && id_ready && !mispred;
    assign flush    = (state_q == FLUSH);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (mispred) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = IDLE;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Entry storage needs no reset: occupancy is governed entirely by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_pred[tail] <= id_pred_taken;
            q_pc[tail]   <= id_pc;
            q_tgt[tail]  <= id_pc + id_imm;
            q_fall[tail] <= id_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispred) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)     head <= head + PTR_W'(1);
            if (push_ok) tail <= tail + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + QC_W'(1);
                2'b01:   count <= count - QC_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_we      <= 1'b0;
            upd_taken   <= 1'b0;
            upd_pc      <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_we   <= pop;
            redirect <= mispred;
            if (pop) begin
                upd_taken <= ex_taken;
                upd_pc    <= q_pc[head];
            end
            if (mispred) redirect_pc <= ex_taken ? q_tgt[head] : q_fall[head];
        end
    end

`ifdef BRC_PERF_CNT_EN
    // Counters step on the same edge that raises upd_we/redirect, so they agree with those pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (pop && branch_cnt != '1)      branch_cnt  <= branch_cnt + CNT_W'(1);
            if (mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

`ifdef BRC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_push = 1'b0, id_pred_taken = 1'b0;
    logic [31:0] id_pc = '0, id_imm = '0;
    logic        id_ready;
    logic        ex_valid = 1'b0, ex_taken = 1'b0;
    logic        redirect, flush, upd_we, upd_taken;
    logic [31:0] redirect_pc, upd_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    int vectors = 0;
    int miscompares = 0;

    branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_push(id_push), .id_pred_taken(id_pred_taken), .id_pc(id_pc), .id_imm(id_imm),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_taken(ex_taken),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .upd_we(upd_we), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of branches plus a "flush cycles remaining" number.
    typedef struct {
        bit        pred;
        bit [31:0] pc;
        bit [31:0] imm;
    } br_t;

    br_t       mq[$];
    int        flush_left = 0;
    bit        e_redirect = 0, e_upd_we = 0, e_upd_taken = 0;
    bit [31:0] e_rpc = 0, e_upd_pc = 0;
    int        e_bc = 0, e_mc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            flush_left = 0;
            e_redirect = 0; e_upd_we = 0; e_upd_taken = 0;
            e_rpc = 0; e_upd_pc = 0; e_bc = 0; e_mc = 0;
        end else begin
            bit ready, wrong;
            br_t h;
            ready      = (flush_left == 0) && (mq.size() < DEPTH);
            wrong      = 0;
            e_redirect = 0;
            e_upd_we   = 0;
            if (flush_left > 0) begin
                flush_left--;
            end else begin
                if (ex_valid && mq.size() > 0) begin
                    h = mq.pop_front();
                    e_upd_we    = 1;
                    e_upd_taken = ex_taken;
                    e_upd_pc    = h.pc;
                    if (e_bc < 65535) e_bc++;
                    if (ex_taken != h.pred) begin
                        wrong      = 1;
                        e_redirect = 1;
                        e_rpc      = ex_taken ? h.pc + h.imm : h.pc + 32'd4;
                        mq.delete();
                        flush_left = FLUSH_CYCLES;
                        if (e_mc < 65535) e_mc++;
                    end
                end
                if (id_push && ready && !wrong)
                    mq.push_back('{pred: id_pred_taken, pc: id_pc, imm: id_imm});
            end
        end
    end

    // Cycle-by-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        chk("id_ready", id_ready, (flush_left == 0 && mq.size() < DEPTH));
        chk("redirect", redirect, e_redirect);
        chk("flush", flush, (flush_left > 0));
        chk("upd_we", upd_we, e_upd_we);
        if (e_upd_we) begin
            chk("upd_pc", upd_pc, e_upd_pc);
            chk("upd_taken", upd_taken, e_upd_taken);
        end
        if (e_redirect) chk("redirect_pc", redirect_pc, e_rpc);
        chk("branch_cnt", branch_cnt, PERF ? e_bc : 0);
        chk("mispred_cnt", mispred_cnt, PERF ? e_mc : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        id_push = 1'b1; id_pc = pc; id_imm = imm; id_pred_taken = pred;
        step();
        id_push = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        ex_valid = 1'b1; ex_taken = taken;
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        // Reset state
        chk("rst id_ready", id_ready, 1);
        chk("rst flush", flush, 0);
        chk("rst upd_we", upd_we, 0);
        chk("rst bcnt", branch_cnt, 0);

        // Correct taken prediction
        push(32'h100, 32'h20, 1'b1);
        resolve(1'b1);
        chk("t2 upd_we", upd_we, 1);
        chk("t2 upd_pc", upd_pc, 32'h100);
        chk("t2 upd_taken", upd_taken, 1);
        chk("t2 redirect", redirect, 0);
        chk("t2 flush", flush, 0);
        chk("t2 bcnt", branch_cnt, PERF ? 1 : 0);

        // Mispredict: predicted taken, actually not taken, with two younger entries
        push(32'h200, 32'h40, 1'b1);
        push(32'h300, 32'h8, 1'b1);
        push(32'h400, 32'h8, 1'b0);
        resolve(1'b0);
        chk("t3 redirect", redirect, 1);
        chk("t3 redirect_pc", redirect_pc, 32'h204);
        chk("t3 flush c1", flush, 1);
        chk("t3 id_ready c1", id_ready, 0);
        push(32'h500, 32'h8, 1'b1);   // ignored during flush
        chk("t3 redirect c2", redirect, 0);
        chk("t3 flush c2", flush, 1);
        chk("t3 id_ready c2", id_ready, 0);
        step();
        chk("t3 flush end", flush, 0);
        chk("t3 id_ready end", id_ready, 1);
        resolve(1'b1);                // queue is empty: ignored
        chk("t3 empty upd_we", upd_we, 0);
        chk("t3 mcnt", mispred_cnt, PERF ? 1 : 0);

        // Mispredict taken with address wrap
        push(32'hFFFF_FFF0, 32'h20, 1'b0);
        resolve(1'b1);
        chk("t4 redirect_pc", redirect_pc, 32'h0000_0010);
        step();
        step();

        // Full queue, dropped push, simultaneous push/pop
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'h100 * i, 32'h4, 1'b1);
        chk("t5 full id_ready", id_ready, 0);
        push(32'h1400, 32'h4, 1'b1);  // dropped
        id_push = 1'b1; id_pc = 32'h1500; id_imm = 32'h4; id_pred_taken = 1'b0;
        resolve(1'b1);                // correct pop, push rejected since full
        id_push = 1'b0;
        chk("t5 simul upd_pc", upd_pc, 32'h1000);
        chk("t5 simul redirect", redirect, 0);
        id_push = 1'b1; id_pc = 32'h1600; id_imm = 32'h4; id_pred_taken = 1'b1;
        resolve(1'b0);                // mispredict with concurrent push
        id_push = 1'b0;
        chk("t5 mis upd_pc", upd_pc, 32'h1100);
        chk("t5 mis redirect_pc", redirect_pc, 32'h1104);
        step();
        step();
        resolve(1'b1);
        chk("t5 empty upd_we", upd_we, 0);
        chk("t5 empty redirect", redirect, 0);
        chk("final bcnt", branch_cnt, PERF ? 5 : 0);
        chk("final mcnt", mispred_cnt, PERF ? 3 : 0);

        // Reset in the middle of a flush
        push(32'h3000, 32'h10, 1'b1);
        resolve(1'b0);
        chk("t6 pre flush", flush, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst flush", flush, 0);
        chk("t6 rst redirect", redirect, 0);
        chk("t6 rst upd_we", upd_we, 0);
        chk("t6 rst mcnt", mispred_cnt, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("t6 id_ready", id_ready, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
